dual_issue_router: RTL
======================

Name: dual_issue_router

Overview:
- Parametrised successor to the dual-pipe decode/issue stage.
- Accepts decoded instruction pairs from the decode modules into an in-order instruction queue of DEPTH entries.
- Each cycle, issues up to two queue-head instructions to the even and odd execution pipes.
- Enforces pipe steering, intra-pair RAW/WAW hazards, stop-instruction halting, stall and flush.

Parameters:
- REG_W, 7, register specifier width.
- CS_W, 8, control-signal width (pipe-select bit excluded).
- IMM_W, 32, immediate width.
- PC_W, 32, program counter width.
- DEPTH, 8, queue entries; power of 2, >=4.
- DUAL_EN, 1, 1 = dual issue allowed; 0 = single issue only (one instruction per cycle).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  discard queue and outputs.
- stall  in  1  freeze issue.
- in_valid  in  1  decode pair valid.
- in_ready  out  1  queue can accept a pair.
- in_slot_vld  in  2  per-slot valid; slot0 is older.
- in_pc  in  PC_W  PC of slot0; slot1 PC = in_pc+4.
- in_pipe  in  2  per-slot pipe: 0 even, 1 odd.
- in_ra, in_rb, in_rc, in_rt  in  2*REG_W each  per-slot registers.
- in_wr  in  2  per-slot: rt is written.
- in_stop  in  2  per-slot stop instruction.
- in_cs  in  2*CS_W  per-slot control.
- in_imm  in  2*IMM_W  per-slot immediate.
- e_valid, o_valid  out  1  even/odd pipe issue valid.
- e_ra, e_rb, e_rc, e_rt / o_ra, o_rb, o_rc, o_rt  out  REG_W each.
- e_cs / o_cs  out  CS_W.
- e_imm / o_imm  out  IMM_W.
- e_pc / o_pc  out  PC_W.
- halted  out  1  stop instruction issued; issue frozen.

Behaviour:
- Reset (rst_n=0 at posedge): queue empty, state RUN, halted=0. All e_*/o_* = 0 and valids = 0.
- in_ready = (DEPTH - count) >= 2 and state != HALT. Computed from the registered count; same-cycle pops are not credited.
- Push: on in_valid & in_ready & !flush, append valid slots in order, slot0 first. in_slot_vld=2'b10 pushes slot1 only, with PC in_pc+4.
- Issue candidates: h0 = head, h1 = head+1.
- Dual issue requires all of:
  - DUAL_EN=1, count>=2, state RUN;
  - pipe(h0) != pipe(h1);
  - !h0.stop;
  - no hazard. Hazard = h0.wr & (h0.rt==h1.ra | h0.rt==h1.rb | h0.rt==h1.rc | (h1.wr & h0.rt==h1.rt)).
- Single issue: otherwise, if count>=1 and state RUN, h0 only goes to its pipe; the other pipe receives valid=0 and all fields 0.
- Same-pipe pairs always serialise over 2 cycles. Ordering is never violated.
- Outputs are registered: an entry at head on cycle N appears on e_*/o_* at cycle N+1. Minimum push-to-issue latency is 2 cycles (push N, at head N+1, visible N+2).
- Empty queue: both valids 0, fields 0.
- Push and pop in the same cycle are allowed; count' = count + pushed - popped.
- FSM:
  - RUN: normal issue.
  - RUN -> HALT when the issued h0 has stop=1.
  - HALT: halted=1, no pops; outputs go to 0/invalid the next cycle; in_ready=0.
  - HALT -> RUN only on flush or reset.
- stall=1: outputs hold their previous values, including valids. No pops; pushes still accepted per in_ready. The FSM holds.
- flush=1: takes priority over stall and push. Queue emptied, outputs zeroed, state RUN, and no push that cycle.
- Priority: rst_n > flush > stall > issue.
- Read and write pointers wrap modulo DEPTH. A count of DEPTH is full, so in_ready=0.
- Reset mid-operation: identical to power-on reset, and all queued entries are lost.

Test Plan:
- Independent pair: slot0 pipe0 rt=5, slot1 pipe1 ra=6/rb=7/rc=8, in_pc=0x100 -> 2 cycles later e_valid=o_valid=1, e_pc=0x100, o_pc=0x104, e_rt=5.
- RAW: slot0 pipe0 wr=1 rt=9, slot1 pipe1 ra=9 -> cycle N: e_valid=1, o_valid=0; N+1: o_valid=1, e_valid=0, o_pc=in_pc+4. Repeat with DUAL_EN=0 and no hazard -> same 2-cycle serialisation.
- Same pipe: two odd instructions, no dependency -> issued on consecutive cycles on the odd port; e_valid=0 both cycles.
- Stop: slot0 stop=1 pipe1, slot1 pipe0 -> o_valid=1 once, then halted=1, in_ready=0, and slot1 never issues. Asserting flush -> halted=0, queue empty, in_ready=1.
- Full/wrap with DEPTH=8: push 4 same-pipe pairs with stall=1 -> count=8, in_ready=0. Release stall -> one issue per cycle, in_ready=1 once count<=6. Continue 20 pairs and check in-order PCs across pointer wrap.
- Stall/flush collision: stall=1 with queue holding 3 entries, then flush=1 and in_valid=1 in the same cycle -> next cycle outputs 0, count=0, the pushed pair is discarded.

Source files
------------

// File: rtl/dual_issue_router.sv
// Dual-issue router: in-order instruction queue feeding the even and odd execution pipes.
// Up to two head entries issue per cycle, subject to pipe steering, intra-pair hazards and stop.
module dual_issue_router #(
    parameter int unsigned REG_W   = 7,
    parameter int unsigned CS_W    = 8,
    parameter int unsigned IMM_W   = 32,
    parameter int unsigned PC_W    = 32,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned DUAL_EN = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               stall,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_slot_vld,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [1:0]         in_pipe,
    input  logic [2*REG_W-1:0] in_ra,
    input  logic [2*REG_W-1:0] in_rb,
    input  logic [2*REG_W-1:0] in_rc,
    input  logic [2*REG_W-1:0] in_rt,
    input  logic [1:0]         in_wr,
    input  logic [1:0]         in_stop,
    input  logic [2*CS_W-1:0]  in_cs,
    input  logic [2*IMM_W-1:0] in_imm,
    output logic               e_valid,
    output logic [REG_W-1:0]   e_ra,
    output logic [REG_W-1:0]   e_rb,
    output logic [REG_W-1:0]   e_rc,
    output logic [REG_W-1:0]   e_rt,
    output logic [CS_W-1:0]    e_cs,
    output logic [IMM_W-1:0]   e_imm,
    output logic [PC_W-1:0]    e_pc,
    output logic               o_valid,
    output logic [REG_W-1:0]   o_ra,
    output logic [REG_W-1:0]   o_rb,
    output logic [REG_W-1:0]   o_rc,
    output logic [REG_W-1:0]   o_rt,
    output logic [CS_W-1:0]    o_cs,
    output logic [IMM_W-1:0]   o_imm,
    output logic [PC_W-1:0]    o_pc,
    output logic               halted
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic             pipe;
        logic             wr;
        logic             stop;
        logic [REG_W-1:0] ra;
        logic [REG_W-1:0] rb;
        logic [REG_W-1:0] rc;
        logic [REG_W-1:0] rt;
        logic [CS_W-1:0]  cs;
        logic [IMM_W-1:0] imm;
    } entry_t;

    typedef enum logic [0:0] {StRun, StHalt} state_e;

    entry_t          mem_q [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    state_e          state_q, state_d;
    entry_t          e_q, e_d, o_q, o_d;
    logic            e_valid_q, e_valid_d, o_valid_q, o_valid_d;

    entry_t     slot0, slot1, h0, h1;
    logic       run, push, hazard, can_single, can_dual;
    logic [1:0] n_push, n_pop;

    assign slot0 = '{pc: in_pc, pipe: in_pipe[0], wr: in_wr[0], stop: in_stop[0],
                     ra: in_ra[REG_W-1:0], rb: in_rb[REG_W-1:0], rc: in_rc[REG_W-1:0],
                     rt: in_rt[REG_W-1:0], cs: in_cs[CS_W-1:0], imm: in_imm[IMM_W-1:0]};
    assign slot1 = '{pc: in_pc + PC_W'(4), pipe: in_pipe[1], wr: in_wr[1], stop: in_stop[1],
                     ra: in_ra[2*REG_W-1:REG_W], rb: in_rb[2*REG_W-1:REG_W],
                     rc: in_rc[2*REG_W-1:REG_W], rt: in_rt[2*REG_W-1:REG_W],
                     cs: in_cs[2*CS_W-1:CS_W], imm: in_imm[2*IMM_W-1:IMM_W]};

    assign h0 = mem_q[rd_ptr_q];
    assign h1 = mem_q[rd_ptr_q + PtrW'(1)];

    assign run      = (state_q == StRun);
    assign in_ready = run && ((CntW'(DEPTH) - count_q) >= CntW'(2));
    assign push     = in_valid && in_ready && !flush;

    // h1 must not read or rewrite a register that h0 produces in the same cycle
    assign hazard = h0.wr & ((h0.rt == h1.ra) | (h0.rt == h1.rb) | (h0.rt == h1.rc) |
                             (h1.wr & (h0.rt == h1.rt)));

    assign can_single = run && (count_q != '0);
    assign can_dual   = (DUAL_EN != 0) && run && (count_q >= CntW'(2)) &&
                        (h0.pipe != h1.pipe) && !h0.stop && !hazard;

    always_comb begin
        n_push    = '0;
        n_pop     = '0;
        state_d   = state_q;
        e_d       = e_q;
        o_d       = o_q;
        e_valid_d = e_valid_q;
        o_valid_d = o_valid_q;
        if (push) begin
            n_push = {1'b0, in_slot_vld[0]} + {1'b0, in_slot_vld[1]};
        end
        if (flush) begin
            state_d   = StRun;
            e_d       = '0;
            o_d       = '0;
            e_valid_d = 1'b0;
            o_valid_d = 1'b0;
        end else if (!stall) begin
            e_d       = '0;
            o_d       = '0;
            e_valid_d = 1'b0;
            o_valid_d = 1'b0;
            if (can_single) begin
                n_pop = can_dual ? 2'd2 : 2'd1;
                if (h0.pipe) begin
                    o_d       = h0;
                    o_valid_d = 1'b1;
                end else begin
                    e_d       = h0;
                    e_valid_d = 1'b1;
                end
                if (can_dual) begin
                    if (h1.pipe) begin
                        o_d       = h1;
                        o_valid_d = 1'b1;
                    end else begin
                        e_d       = h1;
                        e_valid_d = 1'b1;
                    end
                end
                if (h0.stop) begin
                    state_d = StHalt;
                end
            end
        end
    end

    always_comb begin
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + PtrW'(n_pop);
            wr_ptr_d = wr_ptr_q + PtrW'(n_push);
            count_d  = count_q + CntW'(n_push) - CntW'(n_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= StRun;
            e_q       <= '0;
            o_q       <= '0;
            e_valid_q <= 1'b0;
            o_valid_q <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            e_q       <= e_d;
            o_q       <= o_d;
            e_valid_q <= e_valid_d;
            o_valid_q <= o_valid_d;
        end
    end

    // Storage needs no reset: validity is tracked by the pointers and count alone
    always_ff @(posedge clk) begin
        if (push) begin
            if (in_slot_vld[0]) begin
                mem_q[wr_ptr_q] <= slot0;
            end
            if (in_slot_vld[1]) begin
                mem_q[wr_ptr_q + PtrW'(in_slot_vld[0])] <= slot1;
            end
        end
    end

    assign e_valid = e_valid_q;
    assign e_ra    = e_q.ra;
    assign e_rb    = e_q.rb;
    assign e_rc    = e_q.rc;
    assign e_rt    = e_q.rt;
    assign e_cs    = e_q.cs;
    assign e_imm   = e_q.imm;
    assign e_pc    = e_q.pc;
    assign o_valid = o_valid_q;
    assign o_ra    = o_q.ra;
    assign o_rb    = o_q.rb;
    assign o_rc    = o_q.rc;
    assign o_rt    = o_q.rt;
    assign o_cs    = o_q.cs;
    assign o_imm   = o_q.imm;
    assign o_pc    = o_q.pc;
    assign halted  = (state_q == StHalt);

endmodule
